// File: rtl/l1_mmu_arbiter.sv
// N-channel arbiter between the L1 caches and the single l1mmu line port.
// Grants are registered and locked for the whole transaction; completion is a one-cycle ch_done.
module l1_mmu_arbiter #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int RR_EN  = 1,
   localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     sys_clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          ch_req_read,
   input  logic [N_CH-1:0]          ch_req_write,
   input  logic [N_CH*ADDR_W-1:0]   ch_req_addr,
   input  logic [N_CH*LINE_W-1:0]   ch_write_data,
   output logic [N_CH-1:0]          ch_done,
   output logic [LINE_W-1:0]        ch_read_data,
   output logic                     mmu_req_read,
   output logic                     mmu_req_write,
   output logic [ADDR_W-1:0]        mmu_req_addr,
   output logic [LINE_W-1:0]        mmu_write_data,
   input  logic                     mmu_done,
   input  logic [LINE_W-1:0]        mmu_read_data,
   output logic                     busy,
   output logic [ID_W-1:0]          grant_id
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_q, rr_d;
   logic [ID_W-1:0]     gnt_q, gnt_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;
   logic [N_CH-1:0]     done_q, done_d;
   logic                busy_q, busy_d;

   logic [N_CH-1:0]     req_s;
   logic [ID_W-1:0]     idx_s;
   logic [ID_W-1:0]     win_id_s;
   logic                win_found_s;
   logic [ADDR_W-1:0]   win_addr_s;
   logic [LINE_W-1:0]   win_wdata_s;

   // Winner search: upward from the rr pointer with wrap, or lowest index when RR is off.
   always_comb begin
      req_s       = ch_req_read | ch_req_write;
      win_found_s = 1'b0;
      win_id_s    = '0;
      idx_s       = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (RR_EN != 0) begin
            idx_s = ID_W'((int'(rr_q) + k) % N_CH);
         end else begin
            idx_s = ID_W'(k);
         end
         if (!win_found_s && req_s[idx_s]) begin
            win_found_s = 1'b1;
            win_id_s    = idx_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Select the winning channel's address and write line.
   always_comb begin
      win_addr_s  = '0;
      win_wdata_s = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (win_id_s == ID_W'(k)) begin
            win_addr_s  = ch_req_addr[k*ADDR_W +: ADDR_W];
            win_wdata_s = ch_write_data[k*LINE_W +: LINE_W];
         end else begin
            win_addr_s  = win_addr_s;
         end
      end
   end

   // Transaction FSM: next state and next values of every registered output.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      done_d  = '0;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (win_found_s) begin
               state_d = ST_BUSY;
               gnt_d   = win_id_s;
               addr_d  = win_addr_s;
               wdata_d = win_wdata_s;
               // Write wins when a channel raises both request lines.
               wr_d    = ch_req_write[win_id_s];
               rd_d    = ch_req_read[win_id_s] & ~ch_req_write[win_id_s];
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mmu_done) begin
               state_d        = ST_RESP;
               rdata_d        = mmu_read_data;
               rd_d           = 1'b0;
               wr_d           = 1'b0;
               done_d[gnt_q]  = 1'b1;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (gnt_q == ID_W'(N_CH - 1)) begin
               rr_d = '0;
            end else begin
               rr_d = gnt_q + ID_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight request at once.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign ch_done        = done_q;
   assign ch_read_data   = rdata_q;
   assign mmu_req_read   = rd_q;
   assign mmu_req_write  = wr_q;
   assign mmu_req_addr   = addr_q;
   assign mmu_write_data = wdata_q;
   assign busy           = busy_q;
   assign grant_id       = gnt_q;

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Scoreboard bench: three arbiter instances (2ch RR, 2ch fixed, 4ch RR) with a latency-programmable
// downstream responder; a negedge monitor pops expected transactions on every ch_done pulse.
module tb_l1_mmu_arbiter;

   typedef struct packed {
      logic [3:0]   done;
      logic [1:0]   typ;    // {read, write}
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
   } exp_t;

   logic clk;
   logic rst_n;

   // Instance A: N_CH=2, RR_EN=1
   logic [1:0]   rd_a, wr_a, done_a;
   logic [63:0]  addr_a;
   logic [511:0] wd_a;
   logic [255:0] crd_a, mwd_a, mrd_a;
   logic         mrr_a, mrw_a, mdone_a, busy_a;
   logic [31:0]  maddr_a;
   logic [0:0]   gid_a;
   // Instance B: N_CH=2, RR_EN=0
   logic [1:0]   rd_b, wr_b, done_b;
   logic [63:0]  addr_b;
   logic [511:0] wd_b;
   logic [255:0] crd_b, mwd_b, mrd_b;
   logic         mrr_b, mrw_b, mdone_b, busy_b;
   logic [31:0]  maddr_b;
   logic [0:0]   gid_b;
   // Instance C: N_CH=4, RR_EN=1
   logic [3:0]    rd_c, wr_c, done_c;
   logic [127:0]  addr_c;
   logic [1023:0] wd_c;
   logic [255:0]  crd_c, mwd_c, mrd_c;
   logic          mrr_c, mrw_c, mdone_c, stray_c, busy_c;
   logic [31:0]   maddr_c;
   logic [1:0]    gid_c;

   int dly_a, dly_b, dly_c;
   int n_cmp, n_err;
   exp_t qa[$], qb[$], qc[$];
   logic [1:0]   lt[3];
   logic [31:0]  la[3];
   logic [255:0] lw[3];

   l1_mmu_arbiter #(.N_CH(2), .ADDR_W(32), .LINE_W(256), .RR_EN(1)) dut_a (
      .sys_clk(clk), .rst_n(rst_n), .ch_req_read(rd_a), .ch_req_write(wr_a),
      .ch_req_addr(addr_a), .ch_write_data(wd_a), .ch_done(done_a), .ch_read_data(crd_a),
      .mmu_req_read(mrr_a), .mmu_req_write(mrw_a), .mmu_req_addr(maddr_a),
      .mmu_write_data(mwd_a), .mmu_done(mdone_a), .mmu_read_data(mrd_a),
      .busy(busy_a), .grant_id(gid_a));

   l1_mmu_arbiter #(.N_CH(2), .ADDR_W(32), .LINE_W(256), .RR_EN(0)) dut_b (
      .sys_clk(clk), .rst_n(rst_n), .ch_req_read(rd_b), .ch_req_write(wr_b),
      .ch_req_addr(addr_b), .ch_write_data(wd_b), .ch_done(done_b), .ch_read_data(crd_b),
      .mmu_req_read(mrr_b), .mmu_req_write(mrw_b), .mmu_req_addr(maddr_b),
      .mmu_write_data(mwd_b), .mmu_done(mdone_b), .mmu_read_data(mrd_b),
      .busy(busy_b), .grant_id(gid_b));

   l1_mmu_arbiter #(.N_CH(4), .ADDR_W(32), .LINE_W(256), .RR_EN(1)) dut_c (
      .sys_clk(clk), .rst_n(rst_n), .ch_req_read(rd_c), .ch_req_write(wr_c),
      .ch_req_addr(addr_c), .ch_write_data(wd_c), .ch_done(done_c), .ch_read_data(crd_c),
      .mmu_req_read(mrr_c), .mmu_req_write(mrw_c), .mmu_req_addr(maddr_c),
      .mmu_write_data(mwd_c), .mmu_done(mdone_c | stray_c), .mmu_read_data(mrd_c),
      .busy(busy_c), .grant_id(gid_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input int inst, input logic [3:0] d, input logic [1:0] typ,
                       input logic [31:0] addr, input logic [255:0] wdat, input logic [255:0] rdat);
      exp_t e;
      e.done = d; e.typ = typ; e.addr = addr; e.wdata = wdat; e.rdata = rdat;
      case (inst)
         0:       qa.push_back(e);
         1:       qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   task automatic sb(input int inst, input logic [3:0] d, input logic [255:0] rdat);
      exp_t e;
      int   sz;
      case (inst)
         0:       sz = qa.size();
         1:       sz = qb.size();
         default: sz = qc.size();
      endcase
      if (sz == 0) begin
         n_cmp++; n_err++;
         $display("FAIL inst%0d unexpected_done: got ch_done %b expected none", inst, d);
      end else begin
         case (inst)
            0:       e = qa.pop_front();
            1:       e = qb.pop_front();
            default: e = qc.pop_front();
         endcase
         chk($sformatf("inst%0d ch_done", inst), 256'(d), 256'(e.done));
         chk($sformatf("inst%0d req_type", inst), 256'(lt[inst]), 256'(e.typ));
         chk($sformatf("inst%0d mmu_req_addr", inst), 256'(la[inst]), 256'(e.addr));
         chk($sformatf("inst%0d mmu_write_data", inst), lw[inst], e.wdata);
         chk($sformatf("inst%0d ch_read_data", inst), rdat, e.rdata);
      end
   endtask

   task automatic wait_done(input int inst, input int n);
      int got = 0;
      int cyc = 0;
      logic [3:0] d;
      while (got < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         d = (inst == 0) ? {2'b00, done_a} : (inst == 1) ? {2'b00, done_b} : done_c;
         if (d != 4'b0000) got++;
      end
      if (got < n) begin
         n_cmp++; n_err++;
         $display("FAIL inst%0d timeout: got %0d done pulses expected %0d", inst, got, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Downstream responder: pulse mmu_done after the request has been up for dly cycles.
   initial begin
      int ca, cb, cc;
      ca = 0; cb = 0; cc = 0;
      mdone_a = 1'b0; mdone_b = 1'b0; mdone_c = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mrr_a | mrw_a) begin ca++; mdone_a = (ca == dly_a); end
         else begin ca = 0; mdone_a = 1'b0; end
         if (mrr_b | mrw_b) begin cb++; mdone_b = (cb == dly_b); end
         else begin cb = 0; mdone_b = 1'b0; end
         if (mrr_c | mrw_c) begin cc++; mdone_c = (cc == dly_c); end
         else begin cc = 0; mdone_c = 1'b0; end
      end
   end

   // Monitor: latch the downstream request while it is up, score each ch_done pulse.
   initial begin
      for (int i = 0; i < 3; i++) begin lt[i] = 2'b00; la[i] = '0; lw[i] = '0; end
      forever begin
         @(negedge clk);
         if (mrr_a | mrw_a) begin lt[0] = {mrr_a, mrw_a}; la[0] = maddr_a; lw[0] = mwd_a; end
         if (mrr_b | mrw_b) begin lt[1] = {mrr_b, mrw_b}; la[1] = maddr_b; lw[1] = mwd_b; end
         if (mrr_c | mrw_c) begin lt[2] = {mrr_c, mrw_c}; la[2] = maddr_c; lw[2] = mwd_c; end
         if (done_a != 2'b00) sb(0, {2'b00, done_a}, crd_a);
         if (done_b != 2'b00) sb(1, {2'b00, done_b}, crd_b);
         if (done_c != 4'b0000) sb(2, done_c, crd_c);
      end
   end

   localparam logic [255:0] D_A5  = {32{8'hA5}};
   localparam logic [255:0] D_W1  = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [255:0] D_W2  = {4{64'hFEDC_BA98_7654_3210}};

   initial begin
      n_cmp = 0; n_err = 0;
      rd_a = '0; wr_a = '0; addr_a = '0; wd_a = '0; mrd_a = '0;
      rd_b = '0; wr_b = '0; addr_b = '0; wd_b = '0; mrd_b = '0;
      rd_c = '0; wr_c = '0; addr_c = '0; wd_c = '0; mrd_c = '0; stray_c = 1'b0;
      dly_a = 1; dly_b = 1; dly_c = 1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst mmu_req_read", 256'(mrr_a), 256'(0));
      chk("rst mmu_req_write", 256'(mrw_a), 256'(0));
      chk("rst mmu_req_addr", 256'(maddr_a), 256'(0));
      chk("rst ch_done", 256'(done_a), 256'(0));
      chk("rst busy", 256'(busy_a), 256'(0));
      chk("rst grant_id", 256'(gid_c), 256'(0));
      @(posedge clk); #1 rst_n = 1'b1;

      // 1: single read on ch0, done three cycles into the request
      dly_a = 3; mrd_a = D_A5; addr_a[31:0] = 32'h0000_1000;
      push(0, 4'b0001, 2'b10, 32'h0000_1000, '0, D_A5);
      @(posedge clk); #1 rd_a = 2'b01;
      @(negedge clk);
      chk("t1 req in IDLE cycle", 256'(mrr_a), 256'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t1 mmu_req_read held c%0d", i), 256'(mrr_a), 256'(1));
      end
      @(negedge clk);
      chk("t1 req dropped in RESP", 256'(mrr_a), 256'(0));
      chk("t1 ch_done", 256'(done_a), 256'(2'b01));
      chk("t1 busy in RESP", 256'(busy_a), 256'(1));
      @(posedge clk); #1 rd_a = 2'b00;
      @(negedge clk);
      chk("t1 busy back in IDLE", 256'(busy_a), 256'(0));
      chk("t1 ch_done single cycle", 256'(done_a), 256'(0));

      // 2: round-robin alternation with both channels held
      do_reset();
      dly_a = 1; mrd_a = {8{32'hC0DE_0001}};
      addr_a = {32'h0000_3000, 32'h0000_2000};
      for (int i = 0; i < 4; i++)
         push(0, (i % 2 == 0) ? 4'b0001 : 4'b0010, 2'b10,
              (i % 2 == 0) ? 32'h0000_2000 : 32'h0000_3000, '0, {8{32'hC0DE_0001}});
      rd_a = 2'b11;
      wait_done(0, 4);
      rd_a = 2'b00;

      // 3: fixed priority starves ch1 until ch0 stops
      mrd_b = {8{32'h0BB0_0B0B}};
      addr_b = {32'h0000_5000, 32'h0000_4000};
      for (int i = 0; i < 3; i++)
         push(1, 4'b0001, 2'b10, 32'h0000_4000, '0, {8{32'h0BB0_0B0B}});
      push(1, 4'b0010, 2'b10, 32'h0000_5000, '0, {8{32'h0BB0_0B0B}});
      rd_b = 2'b11;
      wait_done(1, 3);
      rd_b = 2'b10;
      wait_done(1, 1);
      rd_b = 2'b00;

      // 4: ch1 write, then ch1 read+write together issues the write
      mrd_a = {8{32'h4444_0004}};
      addr_a[63:32] = 32'h8000_0040; wd_a[511:256] = D_W1;
      push(0, 4'b0010, 2'b01, 32'h8000_0040, D_W1, {8{32'h4444_0004}});
      wr_a = 2'b10;
      wait_done(0, 1);
      wr_a = 2'b00;
      addr_a[63:32] = 32'h8000_0080; wd_a[511:256] = D_W2;
      push(0, 4'b0010, 2'b01, 32'h8000_0080, D_W2, {8{32'h4444_0004}});
      rd_a = 2'b10; wr_a = 2'b10;
      wait_done(0, 1);
      rd_a = 2'b00; wr_a = 2'b00;

      // 5: asynchronous reset in the middle of BUSY, ch0 keeps requesting
      dly_a = 20; mrd_a = {8{32'h5555_0005}}; addr_a[31:0] = 32'h0000_6000;
      rd_a = 2'b01;
      @(negedge clk); @(negedge clk);
      chk("t5 busy before reset", 256'(mrr_a), 256'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("t5 async mmu_req_read", 256'(mrr_a), 256'(0));
      chk("t5 async busy", 256'(busy_a), 256'(0));
      chk("t5 async mmu_req_addr", 256'(maddr_a), 256'(0));
      chk("t5 async ch_read_data", crd_a, 256'(0));
      chk("t5 async mmu_write_data", mwd_a, 256'(0));
      repeat (2) @(posedge clk);
      dly_a = 2;
      push(0, 4'b0001, 2'b10, 32'h0000_6000, '0, {8{32'h5555_0005}});
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("t5 regrant latency", 256'(mrr_a), 256'(1));
      wait_done(0, 1);
      rd_a = 2'b00;

      // 6: four channels, stray mmu_done in IDLE, rotation and pointer after ch3
      mrd_c = {8{32'hCCCC_0004}};
      addr_c = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
      @(posedge clk); #1 stray_c = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 stray_c = 1'b0;
      @(negedge clk);
      chk("t6 stray busy", 256'(busy_c), 256'(0));
      chk("t6 stray mmu_req_read", 256'(mrr_c), 256'(0));
      for (int i = 0; i < 5; i++)
         push(2, 4'b0001 << (i % 4), 2'b10, 32'h0000_0100 * ((i % 4) + 1), '0, {8{32'hCCCC_0004}});
      rd_c = 4'b1111;
      wait_done(2, 5);
      rd_c = 4'b1000;
      push(2, 4'b1000, 2'b10, 32'h0000_0400, '0, {8{32'hCCCC_0004}});
      wait_done(2, 1);
      rd_c = 4'b1111;
      push(2, 4'b0001, 2'b10, 32'h0000_0100, '0, {8{32'hCCCC_0004}});
      wait_done(2, 1);
      rd_c = 4'b0000;

      repeat (3) @(negedge clk);
      chk("leftover expected A", 256'(qa.size()), 256'(0));
      chk("leftover expected B", 256'(qb.size()), 256'(0));
      chk("leftover expected C", 256'(qc.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
